// File: rtl/core_fetch_stream.sv
// core_fetch_stream: block-aligned instruction prefetch front end.
// Issues fetches of LANES halfwords with up to MAX_OUT requests in flight,
// buffers returned halfwords in a DEPTH-entry FIFO and presents a window of
// up to LANES consecutive halfwords to decode. Redirects flush the buffer
// and mark every still-pending request stale so its data is dropped.
module core_fetch_stream #(
  parameter int          LANES    = 2,
  parameter int          DEPTH    = 8,
  parameter int          MAX_OUT  = 2,
  parameter logic [30:0] RESET_PC = 31'd0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             redirect,
  input  logic [30:0]                      redirect_target,
  output logic                             req_valid,
  input  logic                             req_ready,
  output logic [30-$clog2(LANES):0]        req_addr,
  input  logic                             rsp_valid,
  input  logic [16*LANES-1:0]              rsp_data,
  output logic [$clog2(LANES+1)-1:0]       out_count,
  output logic [16*LANES-1:0]              out_data,
  output logic [30:0]                      out_pc,
  input  logic [$clog2(LANES+1)-1:0]       consume
);

  localparam int LW  = $clog2(LANES);
  localparam int AW  = 31 - LW;
  localparam int CW  = $clog2(LANES + 1);
  localparam int PW  = $clog2(DEPTH);
  localparam int OCW = $clog2(DEPTH + 1);
  localparam int OW  = $clog2(MAX_OUT + 1);

  // Architectural state
  logic [15:0]    mem [DEPTH];
  logic [PW-1:0]  head_ptr;
  logic [OCW-1:0] occ;
  logic [30:0]    head_pc;
  logic [AW-1:0]  fetch_pc;
  logic [LW-1:0]  skip;
  logic [OW-1:0]  outstanding;
  logic [OW-1:0]  discard;

  // Next-state values
  logic [15:0]    mem_n [DEPTH];
  logic [PW-1:0]  head_n;
  logic [OCW-1:0] occ_n;
  logic [30:0]    head_pc_n;
  logic [AW-1:0]  fetch_n;
  logic [LW-1:0]  skip_n;
  logic [OW-1:0]  out_n;
  logic [OW-1:0]  disc_n;
  logic [PW-1:0]  tail;
  logic [OCW-1:0] wr_cnt;
  logic [CW-1:0]  cnt_n;
  logic [16*LANES-1:0] data_n;

  logic [15:0] committed;
  logic        req_fire;

  assign req_addr = fetch_pc;
  assign out_pc   = head_pc;
  assign req_fire = req_valid && req_ready;

  // Request only when the FIFO space not yet promised to live in-flight blocks
  // can hold one more full block; stale requests hold no credit.
  always_comb begin
    committed = 16'(occ) + 16'(LANES) * 16'(outstanding - discard);
    req_valid = !rst && !redirect && (outstanding < OW'(MAX_OUT))
                && (committed <= 16'(DEPTH - LANES));
  end

  // Next-state for FIFO, pointers and request bookkeeping; a redirect
  // overrides same-cycle consume and response.
  always_comb begin
    mem_n     = mem;
    head_n    = head_ptr;
    occ_n     = occ;
    head_pc_n = head_pc;
    fetch_n   = fetch_pc;
    skip_n    = skip;
    out_n     = outstanding;
    disc_n    = discard;
    wr_cnt    = '0;
    tail      = head_ptr + PW'(occ);
    if (redirect) begin
      head_n    = '0;
      occ_n     = '0;
      head_pc_n = redirect_target;
      fetch_n   = redirect_target[30:LW];
      skip_n    = redirect_target[LW-1:0];
      out_n     = outstanding - OW'(rsp_valid);
      disc_n    = outstanding - OW'(rsp_valid);
    end else begin
      out_n = outstanding + OW'(req_fire) - OW'(rsp_valid);
      if (req_fire) begin
        fetch_n = fetch_pc + AW'(1);
      end
      if (rsp_valid) begin
        if (discard != '0) begin
          disc_n = discard - OW'(1);
        end else begin
          for (int i = 0; i < LANES; i++) begin
            if (LW'(i) >= skip) begin
              mem_n[tail + PW'(i) - PW'(skip)] = rsp_data[16*i +: 16];
            end
          end
          wr_cnt = OCW'(LANES) - OCW'(skip);
          skip_n = '0;
        end
      end
      head_n    = head_ptr + PW'(consume);
      occ_n     = occ - OCW'(consume) + wr_cnt;
      head_pc_n = head_pc + 31'(consume);
    end
  end

  // Window seen by decode next cycle, built from the post-update FIFO;
  // lanes past the valid count read as zero.
  always_comb begin
    cnt_n  = (occ_n >= OCW'(LANES)) ? CW'(LANES) : CW'(occ_n);
    data_n = '0;
    for (int i = 0; i < LANES; i++) begin
      if (CW'(i) < cnt_n) begin
        data_n[16*i +: 16] = mem_n[head_n + PW'(i)];
      end
    end
  end

  // FIFO storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    mem <= mem_n;
  end

  // Control state and registered decode window.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr    <= '0;
      occ         <= '0;
      head_pc     <= RESET_PC;
      fetch_pc    <= RESET_PC[30:LW];
      skip        <= RESET_PC[LW-1:0];
      outstanding <= '0;
      discard     <= '0;
      out_count   <= '0;
      out_data    <= '0;
    end else begin
      head_ptr    <= head_n;
      occ         <= occ_n;
      head_pc     <= head_pc_n;
      fetch_pc    <= fetch_n;
      skip        <= skip_n;
      outstanding <= out_n;
      discard     <= disc_n;
      out_count   <= cnt_n;
      out_data    <= data_n;
    end
  end

endmodule

// File: tb/tb_core_fetch_stream.sv
// Self-checking bench for core_fetch_stream: a halfword-stream model with a
// pending-request list is stepped alongside the DUT, a simple in-order
// memory answers requests, and directed phases pin key values literally.
module tb_core_fetch_stream;

  localparam int          LANES    = 2;
  localparam int          DEPTH    = 8;
  localparam int          MAX_OUT  = 2;
  localparam logic [30:0] RESET_PC = 31'd0;
  localparam int          LW       = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [30:0] redirect_target;
  logic        req_valid;
  logic        req_ready;
  logic [29:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  out_count;
  logic [31:0] out_data;
  logic [30:0] out_pc;
  logic [1:0]  consume;

  core_fetch_stream #(
    .LANES(LANES), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_target(redirect_target),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .out_count(out_count),
    .out_data(out_data), .out_pc(out_pc), .consume(consume)
  );

  always #5 clk = ~clk;

  typedef struct { logic [30:0] pc; logic [15:0] d; } hw_t;
  typedef struct { logic [29:0] blk; bit stale; } pend_t;
  typedef struct { logic [29:0] blk; int due; } mreq_t;

  hw_t   q[$];
  pend_t pend[$];
  mreq_t mq[$];
  logic [30:0] m_head_pc;
  logic [30:0] m_want;
  logic [29:0] m_fetch;
  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int mem_lat = 1;

  function automatic logic [15:0] hw_of(logic [30:0] pc);
    return pc[15:0] ^ 16'hA5C3;
  endfunction

  function void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic model_reset();
    q.delete();
    pend.delete();
    m_head_pc = RESET_PC;
    m_want    = RESET_PC;
    m_fetch   = RESET_PC[30:LW];
  endtask

  // Drive one cycle of inputs, answer from memory, then advance the model
  // to what the coming clock edge must produce.
  task automatic applyStimulus(input bit r, input bit redir, input logic [30:0] tgt,
                               input bit rdy, input int cons);
    int c;
    int avail;
    int live;
    pend_t e;
    logic exp_valid;
    logic [30:0] pc;
    avail = (q.size() < LANES) ? q.size() : LANES;
    c = (cons < 0) ? avail : cons;
    rst = r;
    redirect = redir;
    redirect_target = tgt;
    req_ready = rdy;
    consume = 2'(c);
    rsp_valid = 1'b0;
    rsp_data = '0;
    if (r) begin
      mq.delete();
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      rsp_valid = 1'b1;
      for (int i = 0; i < LANES; i++)
        rsp_data[16*i +: 16] = hw_of((31'(mq[0].blk) << LW) + 31'(i));
      mq.delete(0);
    end
    #1;
    live = 0;
    foreach (pend[k]) if (!pend[k].stale) live++;
    exp_valid = !r && !redir && (pend.size() < MAX_OUT)
                && ((DEPTH - q.size() - LANES * live) >= LANES);
    check("req_valid", 64'(req_valid), 64'(exp_valid));
    if (!r && req_valid && rdy) mq.push_back('{blk: req_addr, due: cyc + mem_lat});
    if (r) begin
      model_reset();
    end else begin
      if (rsp_valid) begin
        check("rsp_has_request", 64'(pend.size() > 0), 64'(1));
        if (pend.size() > 0) begin
          e = pend.pop_front();
          if (!e.stale && !redir) begin
            for (int i = 0; i < LANES; i++) begin
              pc = (31'(e.blk) << LW) + 31'(i);
              if (pc == m_want) begin
                q.push_back('{pc: pc, d: hw_of(pc)});
                m_want = m_want + 31'd1;
              end
            end
          end
        end
      end
      if (redir) begin
        q.delete();
        foreach (pend[k]) pend[k].stale = 1'b1;
        m_head_pc = tgt;
        m_want    = tgt;
        m_fetch   = tgt[30:LW];
      end else begin
        for (int k = 0; k < c; k++) if (q.size() > 0) q.delete(0);
        m_head_pc = m_head_pc + 31'(c);
      end
      if (exp_valid && rdy) begin
        pend.push_back('{blk: m_fetch, stale: 1'b0});
        m_fetch = m_fetch + 30'd1;
      end
    end
    cyc++;
  endtask

  // Compare registered outputs against the model after the edge.
  task automatic checkOutput();
    int exp_cnt;
    exp_cnt = (q.size() < LANES) ? q.size() : LANES;
    check("out_count", 64'(out_count), 64'(exp_cnt));
    check("out_pc", 64'(out_pc), 64'(m_head_pc));
    check("req_addr", 64'(req_addr), 64'(m_fetch));
    for (int i = 0; i < exp_cnt; i++)
      check("out_data_lane", 64'(out_data[16*i +: 16]), 64'(q[i].d));
  endtask

  task automatic step(input bit r, input bit redir, input logic [30:0] tgt,
                      input bit rdy, input int cons);
    applyStimulus(r, redir, tgt, rdy, cons);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_target = '0; req_ready = 1'b0;
    consume = '0; rsp_valid = 1'b0; rsp_data = '0;
    model_reset();
    @(negedge clk);

    $display("[TB] reset");
    step(1, 0, 31'h0, 0, 0);
    step(1, 0, 31'h0, 0, 0);
    check("rst_out_count", 64'(out_count), 64'(0));
    check("rst_out_pc", 64'(out_pc), 64'(0));
    check("rst_req_addr", 64'(req_addr), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));

    $display("[TB] streaming with 1-cycle memory");
    step(0, 0, 31'h0, 1, -1);
    step(0, 0, 31'h0, 1, -1);
    check("fill_out_count", 64'(out_count), 64'(2));
    check("fill_out_pc", 64'(out_pc), 64'(0));
    check("fill_out_data", 64'(out_data), 64'(32'hA5C2_A5C3));
    for (int k = 0; k < 10; k++) step(0, 0, 31'h0, 1, -1);
    check("stream_out_pc", 64'(out_pc), 64'(20));
    check("stream_out_count", 64'(out_count), 64'(2));
    check("stream_req_addr", 64'(req_addr), 64'(12));

    $display("[TB] redirect to 0x105");
    step(0, 1, 31'h105, 1, -1);
    check("redir105_out_count", 64'(out_count), 64'(0));
    check("redir105_out_pc", 64'(out_pc), 64'(31'h105));
    check("redir105_req_addr", 64'(req_addr), 64'(30'h82));
    for (int k = 0; k < 20 && out_count == 2'd0; k++) step(0, 0, 31'h0, 1, 0);
    check("redir105_first_count", 64'(out_count), 64'(1));
    check("redir105_first_pc", 64'(out_pc), 64'(31'h105));
    check("redir105_lane0", 64'(out_data[15:0]), 64'(16'hA4C6));

    $display("[TB] redirect with two requests in flight");
    mem_lat = 3;
    for (int k = 0; k < 20 && pend.size() != 2; k++) step(0, 0, 31'h0, 1, -1);
    check("inflight_pending", 64'(pend.size()), 64'(2));
    step(0, 1, 31'h40, 1, 0);
    for (int k = 0; k < 20 && out_count == 2'd0; k++) step(0, 0, 31'h0, 1, 0);
    check("redir40_out_count", 64'(out_count), 64'(2));
    check("redir40_out_pc", 64'(out_pc), 64'(31'h40));
    check("redir40_lane0", 64'(out_data[15:0]), 64'(16'hA583));

    $display("[TB] fill with consume held at zero");
    mem_lat = 1;
    step(0, 1, 31'h60, 1, 0);
    for (int k = 0; k < 15; k++) step(0, 0, 31'h0, 1, 0);
    check("full_model_occ", 64'(q.size()), 64'(8));
    check("full_req_valid", 64'(req_valid), 64'(0));
    check("full_out_pc", 64'(out_pc), 64'(31'h60));
    check("full_out_data", 64'(out_data), 64'(32'hA5A2_A5A3));
    for (int k = 0; k < 4; k++) step(0, 0, 31'h0, 1, 2);
    check("drain_out_pc", 64'(out_pc), 64'(31'h68));
    for (int k = 0; k < 4; k++) step(0, 0, 31'h0, 1, -1);

    $display("[TB] memory stall");
    step(0, 1, 31'h200, 0, 0);
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 31'h0, 0, 0);
      check("stall_req_valid", 64'(req_valid), 64'(1));
      check("stall_req_addr", 64'(req_addr), 64'(30'h100));
      check("stall_pending", 64'(pend.size()), 64'(0));
    end
    for (int k = 0; k < 8; k++) step(0, 0, 31'h0, 1, -1);

    $display("[TB] redirect with same-cycle response and consume");
    check("coinc_pre_count", 64'(out_count), 64'(2));
    step(0, 1, 31'h333, 1, 2);
    check("coinc_out_count", 64'(out_count), 64'(0));
    check("coinc_out_pc", 64'(out_pc), 64'(31'h333));
    check("coinc_req_addr", 64'(req_addr), 64'(30'h199));
    for (int k = 0; k < 8; k++) step(0, 0, 31'h0, 1, -1);

    $display("[TB] reset mid-stream");
    step(1, 0, 31'h0, 1, -1);
    check("midrst_out_count", 64'(out_count), 64'(0));
    check("midrst_out_pc", 64'(out_pc), 64'(0));
    check("midrst_req_addr", 64'(req_addr), 64'(0));
    step(0, 0, 31'h0, 1, -1);
    step(0, 0, 31'h0, 1, -1);
    check("postrst_out_count", 64'(out_count), 64'(2));
    check("postrst_out_data", 64'(out_data), 64'(32'hA5C2_A5C3));
    for (int k = 0; k < 6; k++) step(0, 0, 31'h0, 1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_fetch_stream.md
# core_fetch_stream

Parametrised instruction fetch front end that replaces the single-word, single-outstanding fetch path. It issues block-aligned fetches of LANES halfwords, keeps up to MAX_OUT requests in flight, buffers returned halfwords in a DEPTH-entry prefetch FIFO and presents a variable-length window of consecutive halfwords to the decoder. It sits between the instruction memory port and decode. Branch redirects flush the buffer and silently drop stale in-flight responses.

## Interface
- LANES, 2, halfwords per fetch block; power of two, 2..8.
- DEPTH, 8, prefetch FIFO capacity in halfwords; power of two, multiple of LANES, at least 2*LANES.
- MAX_OUT, 2, maximum outstanding memory requests, 1..7.
- RESET_PC, 0, halfword pointer (31 bits) fetched after reset.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- redirect  in  1  branch/flush request.
- redirect_target  in  31  halfword pointer to resume at.
- req_valid  out  1  fetch request.
- req_ready  in  1  memory accepts request (handshake = valid && ready).
- req_addr  out  31-log2(LANES)  block pointer.
- rsp_valid  in  1  one in-order response block.
- rsp_data  in  16*LANES  halfword i at bits [16i+15:16i].
- out_count  out  clog2(LANES+1)  valid halfwords in window, min(occupancy, LANES).
- out_data  out  16*LANES  window; lane 0 = oldest halfword.
- out_pc  out  31  halfword pointer of lane 0.
- consume  in  clog2(LANES+1)  halfwords taken this cycle; must be <= out_count.

## Operation
- State: FIFO (head/tail pointers, occupancy 0..DEPTH), fetch_pc (next block pointer), skip (low-halfword drop count for first block after redirect), outstanding (0..MAX_OUT), discard (0..MAX_OUT), head_pc.
- Issue rule: req_valid = !redirect && outstanding < MAX_OUT && DEPTH - occupancy - LANES*(outstanding - discard) >= LANES. Handshake increments outstanding, advances fetch_pc by 1 (wraps modulo address width).
- req_addr = fetch_pc; held stable while req_valid && !req_ready.
- Response: decrements outstanding. If discard > 0, data dropped and discard decrements. Otherwise halfwords skip..LANES-1 are written to FIFO in lane order and skip clears to 0.
- Consume: removes consume halfwords from head; head_pc advances by consume modulo 2^31.
- Redirect: FIFO emptied; head_pc = redirect_target; fetch_pc = redirect_target >> log2(LANES); skip = redirect_target low log2(LANES) bits; discard = outstanding - rsp_valid (all still-pending requests become stale). Same-cycle consume ignored, same-cycle response dropped.
- Reset: FIFO empty, outstanding = discard = 0, head_pc = RESET_PC, fetch_pc = RESET_PC block, skip = RESET_PC offset. Memory side is reset together; no responses for pre-reset requests are delivered.
- Occupancy never exceeds DEPTH; the credit rule guarantees every accepted non-stale response fits.

## Timing
- All outputs registered except req_valid (combinational on redirect and state).
- Reset values: req_valid 0 while rst, out_count 0, out_data 0, out_pc RESET_PC, req_addr RESET_PC block.
- Redirect at cycle t: out_count 0 at t+1; first new request earliest t+1.
- Response at cycle r: halfwords visible in out_count/out_data at r+1.
- Consume at cycle c: out_count/out_pc reflect removal at c+1; simultaneous consume and response both applied.
- Sustained throughput: LANES halfwords/cycle with memory latency <= MAX_OUT cycles and consume = LANES.

## Test plan
- LANES=2, DEPTH=8, MAX_OUT=2, 1-cycle memory, consume=out_count -> req_addr 0,1,2,...; out_pc 0,2,4,... every cycle after fill; no bubbles.
- Redirect to 0x105 -> req_addr 0x82 next cycle; after its response out_count=1, out_pc=0x105, out_data lane 0 = rsp_data[31:16].
- Two requests in flight, redirect to 0x40 -> both stale responses dropped, out_count stays 0 until block 0x20 returns, then out_pc=0x40.
- consume=0 continuously -> occupancy reaches 8, req_valid deasserts with no response lost; draining restores original order.
- req_ready=0 for 5 cycles -> req_addr and req_valid stable; outstanding unchanged.
- Redirect coinciding with rsp_valid and consume=2 -> response dropped, consume ignored, out_pc = target; reset asserted mid-stream -> out_count 0, out_pc RESET_PC next cycle.
